// File: rtl/mwadd_pkg.sv
// Shared types and default sizing for the multi-word sequential adder.
package mwadd_pkg;

  localparam int unsigned WORD_W_DEF    = 16;
  localparam int unsigned NUM_WORDS_DEF = 4;
  localparam int unsigned SKIP_BLK_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_skip_slice.sv
// Combinational WORD_W-bit carry-skip adder: ripple inside each SKIP_BLK block,
// block carry bypassed when every bit of the block propagates.
module carry_skip_slice #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned SKIP_BLK = 4
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned NUM_BLK = WORD_W / SKIP_BLK;

  logic [WORD_W-1:0] w_p;
  logic [WORD_W-1:0] w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    logic c_blk;
    logic c_rip;
    sum   = '0;
    c_blk = cin;
    c_rip = cin;
    for (int unsigned k = 0; k < NUM_BLK; k++) begin
      c_rip = c_blk;
      for (int unsigned j = 0; j < SKIP_BLK; j++) begin
        sum[k*SKIP_BLK + j] = w_p[k*SKIP_BLK + j] ^ c_rip;
        c_rip               = w_g[k*SKIP_BLK + j] | (w_p[k*SKIP_BLK + j] & c_rip);
      end
      // A fully propagating block passes its incoming carry straight through.
      c_blk = (&w_p[k*SKIP_BLK +: SKIP_BLK]) ? c_blk : c_rip;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: streams operands LSW-first through one carry-skip slice.
// Optional subtract mode (op_sub port) when MWADD_SUB_EN is defined.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned SKIP_BLK  = SKIP_BLK_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef MWADD_SUB_EN
  input  logic                          op_sub,
`endif
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   op_a,
  input  logic [WORD_W*NUM_WORDS-1:0]   op_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   res_sum,
  output logic                          res_cout,
  output logic                          busy
);

  localparam int unsigned TOTAL_W = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [TOTAL_W-1:0] r_a;
  logic [TOTAL_W-1:0] r_b;
  logic [TOTAL_W-1:0] r_sum;
  logic               r_cout;
  logic               r_sub;

  logic               w_accept;
  logic               w_last;
  logic [WORD_W-1:0]  w_a_slice;
  logic [WORD_W-1:0]  w_b_slice;
  logic [WORD_W-1:0]  w_s_slice;
  logic               w_s_cout;
  logic               w_sub_in;

`ifdef MWADD_SUB_EN
  assign w_sub_in = op_sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_accept  = start_valid && (r_state == IDLE);
  assign w_last    = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_a_slice = r_a[32'(r_idx) * WORD_W +: WORD_W];
  assign w_b_slice = r_sub ? ~r_b[32'(r_idx) * WORD_W +: WORD_W]
                           :  r_b[32'(r_idx) * WORD_W +: WORD_W];

  carry_skip_slice #(
    .WORD_W   (WORD_W),
    .SKIP_BLK (SKIP_BLK)
  ) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_s_slice),
    .cout (w_s_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-slice datapath; the carry register chains slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_sub   <= w_sub_in;
      r_idx   <= '0;
      r_carry <= w_sub_in;
    end else if (r_state == RUN) begin
      r_sum[32'(r_idx) * WORD_W +: WORD_W] <= w_s_slice;
      r_carry <= w_s_cout;
      if (w_last) begin
        r_cout <= w_s_cout;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign res_sum  = r_sum;
  assign res_cout = r_cout;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases plus random operands
// against an arithmetic reference; subtract cases compiled in with MWADD_SUB_EN.
module tb_multiword_add_seq;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned TOTAL_W   = WORD_W * NUM_WORDS;

  logic               clk = 1'b0;
  logic               rst;
  logic               op_sub;
  logic               start_valid;
  logic               start_ready;
  logic [TOTAL_W-1:0] op_a;
  logic [TOTAL_W-1:0] op_b;
  logic               res_valid;
  logic               res_ready;
  logic [TOTAL_W-1:0] res_sum;
  logic               res_cout;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multiword_add_seq dut (
    .clk         (clk),
    .rst         (rst),
`ifdef MWADD_SUB_EN
    .op_sub      (op_sub),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain wide arithmetic on the operands as integers.
  task automatic ref_model(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                           input logic sub, output logic [TOTAL_W-1:0] s, output logic c);
    logic [TOTAL_W:0] wide;
    if (sub) begin
      s = a - b;
      c = (a >= b);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s = wide[TOTAL_W-1:0];
      c = wide[TOTAL_W];
    end
  endtask

  // One full transaction: offer, count latency, hold in DONE, then release.
  task automatic run_op(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                        input logic sub, input bit noisy, input int hold);
    logic [TOTAL_W-1:0] exp_s;
    logic               exp_c;
    int                 cnt;
    ref_model(a, b, sub, exp_s, exp_c);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
    check("start_ready_idle", 128'(start_ready), 128'(1));
    @(posedge clk); #1;
    if (noisy) begin
      op_a = 64'h1234_5678_9ABC_DEF0;
      op_b = {$urandom, $urandom};
      op_sub = 1'b0;
    end else begin
      start_valid = 1'b0;
    end
    check("run_start_ready", 128'(start_ready), 128'(0));
    check("run_busy", 128'(busy), 128'(1));
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    start_valid = 1'b0;
    check("latency", 128'(cnt), 128'(NUM_WORDS));
    check("sum", 128'(res_sum), 128'(exp_s));
    check("cout", 128'(res_cout), 128'(exp_c));
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'(i % 2);
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      @(posedge clk); #1;
      check("hold_valid", 128'(res_valid), 128'(1));
      check("hold_sum", 128'(res_sum), 128'(exp_s));
      check("hold_cout", 128'(res_cout), 128'(exp_c));
      check("hold_start_ready", 128'(start_ready), 128'(0));
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("release_valid", 128'(res_valid), 128'(0));
    check("release_start_ready", 128'(start_ready), 128'(1));
    check("release_busy", 128'(busy), 128'(0));
    check("release_sum_kept", 128'(res_sum), 128'(exp_s));
  endtask

  initial begin
    rst = 1'b1; op_sub = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(res_valid), 128'(0));
    check("rst_start_ready", 128'(start_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_sum", 128'(res_sum), 128'(0));
    check("rst_cout", 128'(res_cout), 128'(0));
    rst = 1'b0;

    // res_ready while idle must do nothing.
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("idle_ready_valid", 128'(res_valid), 128'(0));

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hA0A0_58F4_0F3D_C8CA, 64'hA0A0_F4F4_0F0F_C8CA, 1'b0, 1'b0, 0);
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 5);
    run_op(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F1, 1'b0, 1'b1, 0);

    // Abort on the second RUN cycle.
    @(negedge clk);
    op_a = 64'hDEAD_BEEF_CAFE_F00D; op_b = 64'h1111_2222_3333_4444; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", 128'(res_valid), 128'(0));
    check("abort_start_ready", 128'(start_ready), 128'(1));
    check("abort_sum", 128'(res_sum), 128'(0));
    check("abort_cout", 128'(res_cout), 128'(0));
    run_op(64'd3, 64'd4, 1'b0, 1'b0, 0);

`ifdef MWADD_SUB_EN
    run_op(64'd5, 64'd7, 1'b1, 1'b0, 0);
    run_op(64'd7, 64'd5, 1'b1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 0);
`endif

    for (int t = 0; t < 25; t++) begin
      logic [TOTAL_W-1:0] ra;
      logic [TOTAL_W-1:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 5 == 0) rb = ~ra;
`ifdef MWADD_SUB_EN
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
`else
      run_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
